alu_writeback_pc: RTL and testbench
===================================

ALU_WRITEBACK_PC -- requirements
Module: alu_writeback_pc

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 (rising edge); reset input 1 (synchronous, active-high).
REQ-002 in_valid input 1: an instruction result is presented.
REQ-003 in_ready output 1: the block can accept this cycle.
REQ-004 is_imm input 1: 1 means immediate-load instruction, 0 means compute instruction.
REQ-005 imm input 15: immediate value, used when is_imm=1.
REQ-006 alu_out input 16: ALU result.
REQ-007 alu_zr input 1: ALU zero flag.
REQ-008 alu_ng input 1: ALU negative flag.
REQ-009 dest input 3: destination enables, [2]=A, [1]=D, [0]=M.
REQ-010 jmp input 3: jump conditions, [2]=lt, [1]=eq, [0]=gt.
REQ-011 a_reg output 16: A register (address/operand).
REQ-012 d_reg output 16: D register.
REQ-013 pc output 16: program counter.
REQ-014 mem_wr output 1: memory write request.
REQ-015 mem_addr output 16: write address.
REQ-016 mem_wdata output 16: write data.
REQ-017 mem_ack input 1: memory write accepted.
REQ-018 retired output 16: retired-instruction count (present only with the macro, see REQ-033).

Function
REQ-019 The FSM SHALL have two states: IDLE (in_ready=1) and MEMWAIT (in_ready=0); in_ready SHALL be 0 whenever reset=1.
REQ-020 An instruction SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; all of its register updates SHALL take effect on that edge (latency 1 cycle).
REQ-021 is_imm=1: a_reg <= {1'b0, imm}; dest, jmp and ALU inputs are ignored; pc <= pc+1.
REQ-022 is_imm=0, dest[2]=1: a_reg <= alu_out.
REQ-023 is_imm=0, dest[1]=1: d_reg <= alu_out.
REQ-024 is_imm=0, dest[0]=1: mem_addr <= a_reg value from before the edge, mem_wdata <= alu_out, and the FSM SHALL move to MEMWAIT with mem_wr=1 from the next cycle.
REQ-025 Jump taken = (jmp[2]&alu_ng) | (jmp[1]&alu_zr) | (jmp[0]&~alu_ng&~alu_zr), evaluated for is_imm=0 only.
REQ-026 When the jump is taken, pc SHALL load the a_reg value from before the edge, even when dest[2] writes A in the same instruction.
REQ-027 When no jump is taken, pc SHALL increment by 1 modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-028 In MEMWAIT: mem_wr, mem_addr and mem_wdata SHALL hold stable until mem_ack=1 is sampled; on that edge mem_wr SHALL go to 0 and the FSM SHALL return to IDLE (in_ready=1 the following cycle).
REQ-029 mem_ack SHALL be ignored while mem_wr=0.
REQ-030 in_valid while in MEMWAIT SHALL be ignored: no state changes, and the upstream holds its inputs.

Reset
REQ-031 On a clk edge with reset=1: a_reg=0, d_reg=0, pc=0, mem_wr=0, mem_addr=0, mem_wdata=0, FSM=IDLE, and retired=0 if present; reset has priority over acceptance and mem_ack.
REQ-032 Reset during MEMWAIT SHALL abandon the pending write: mem_wr=0 on the reset edge, and no write is completed.

Configuration
REQ-033 Macro RETIRE_COUNTER_EN.
- Defined: the retired output exists; it increments by 1 (wrapping at 2^16) on each accepted instruction with no pending write, or on the mem_ack edge for write instructions.
- Undefined: the port and its counter are absent, and all other behaviour is identical.

Verification
REQ-034 Reset, then is_imm=1, imm=0x1234 -> a_reg=0x1234, pc=0x0001, mem_wr=0.
REQ-035 a_reg=0x0010, is_imm=0, dest=3'b011, alu_out=0xBEEF -> d_reg=0xBEEF, a_reg=0x0010, next cycle mem_wr=1, mem_addr=0x0010, mem_wdata=0xBEEF, in_ready=0; ack delayed 3 cycles -> outputs held; after ack mem_wr=0, in_ready=1.
REQ-036 a_reg=0x0040, dest=3'b100, alu_out=0x0099, jmp=3'b010, alu_zr=1 -> pc=0x0040 (old A), a_reg=0x0099.
REQ-037 jmp=3'b001, alu_ng=1 -> not taken, pc+1; with pc=0xFFFF -> pc=0x0000.
REQ-038 Reset asserted in the second MEMWAIT cycle -> mem_wr=0, all registers 0, and in_ready=1 the cycle after reset deasserts.
REQ-039 With RETIRE_COUNTER_EN defined: 3 immediates plus 1 write (acked) -> retired=4, and retired=3 until the ack edge.

Source files
------------

// File: rtl/alu_writeback_pc.sv
// Writeback stage of a Hack-style CPU: commits A/D registers, steers the PC and
// launches a handshaked memory write. Optional retire counter via `RETIRE_COUNTER_EN`.
module alu_writeback_pc (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_imm,
    input  logic [14:0] imm,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    input  logic [2:0]  dest,
    input  logic [2:0]  jmp,
    output logic [15:0] a_reg,
    output logic [15:0] d_reg,
    output logic [15:0] pc,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack
`ifdef RETIRE_COUNTER_EN
    ,
    output logic [15:0] retired
`endif
);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MEMWAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [15:0] pc_q, pc_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        jump_s;
`ifdef RETIRE_COUNTER_EN
    logic [15:0] retired_q, retired_d;
`endif

    // Jump condition decode from ALU flags
    always_comb begin
        jump_s = (jmp[2] & alu_ng) | (jmp[1] & alu_zr) | (jmp[0] & ~alu_ng & ~alu_zr);
    end

    // Next-state logic: instruction commit in IDLE, write handshake in MEMWAIT
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        pc_d    = pc_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef RETIRE_COUNTER_EN
        retired_d = retired_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (is_imm) begin
                        a_d  = {1'b0, imm};
                        pc_d = pc_q + 16'd1;
`ifdef RETIRE_COUNTER_EN
                        retired_d = retired_q + 16'd1;
`endif
                    end else begin
                        // PC and memory address both use the A value from before this edge
                        if (dest[2]) begin
                            a_d = alu_out;
                        end else begin
                            a_d = a_q;
                        end
                        if (dest[1]) begin
                            d_d = alu_out;
                        end else begin
                            d_d = d_q;
                        end
                        if (dest[0]) begin
                            addr_d  = a_q;
                            wdata_d = alu_out;
                            wr_d    = 1'b1;
                            state_d = S_MEMWAIT;
                        end else begin
`ifdef RETIRE_COUNTER_EN
                            retired_d = retired_q + 16'd1;
`endif
                            state_d = S_IDLE;
                        end
                        if (jump_s) begin
                            pc_d = a_q;
                        end else begin
                            pc_d = pc_q + 16'd1;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MEMWAIT: begin
                if (mem_ack) begin
                    wr_d    = 1'b0;
                    state_d = S_IDLE;
`ifdef RETIRE_COUNTER_EN
                    retired_d = retired_q + 16'd1;
`endif
                end else begin
                    state_d = S_MEMWAIT;
                end
            end
            default: begin
                wr_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and architectural register update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= 16'd0;
            d_q     <= 16'd0;
            pc_q    <= 16'd0;
            wr_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
`ifdef RETIRE_COUNTER_EN
            retired_q <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            pc_q    <= pc_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef RETIRE_COUNTER_EN
            retired_q <= retired_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE) & ~reset;
    assign a_reg     = a_q;
    assign d_reg     = d_q;
    assign pc        = pc_q;
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
`ifdef RETIRE_COUNTER_EN
    assign retired   = retired_q;
`endif

endmodule

// File: tb/tb_alu_writeback_pc.sv
// Directed self-checking bench for alu_writeback_pc with hand-computed expectations.
module tb_alu_writeback_pc;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        is_imm;
    logic [14:0] imm;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic [2:0]  dest;
    logic [2:0]  jmp;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic [15:0] pc;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
`ifdef RETIRE_COUNTER_EN
    logic [15:0] retired;
`endif

    int n_vec;
    int n_err;

    alu_writeback_pc dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_imm    (is_imm),
        .imm       (imm),
        .alu_out   (alu_out),
        .alu_zr    (alu_zr),
        .alu_ng    (alu_ng),
        .dest      (dest),
        .jmp       (jmp),
        .a_reg     (a_reg),
        .d_reg     (d_reg),
        .pc        (pc),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack)
`ifdef RETIRE_COUNTER_EN
        ,
        .retired   (retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        is_imm   = 1'b0;
        imm      = 15'd0;
        alu_out  = 16'd0;
        alu_zr   = 1'b0;
        alu_ng   = 1'b0;
        dest     = 3'b000;
        jmp      = 3'b000;
    endtask

    task automatic issue_imm(input logic [14:0] v);
        idle_inputs();
        in_valid = 1'b1;
        is_imm   = 1'b1;
        imm      = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic issue_c(input logic [2:0] d, input logic [2:0] j, input logic [15:0] r,
                           input logic zr, input logic ng);
        idle_inputs();
        in_valid = 1'b1;
        dest     = d;
        jmp      = j;
        alu_out  = r;
        alu_zr   = zr;
        alu_ng   = ng;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        mem_ack = 1'b0;
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        check_val("rst_a", a_reg, 16'h0000);
        check_val("rst_d", d_reg, 16'h0000);
        check_val("rst_pc", pc, 16'h0000);
        check_val("rst_wr", {15'd0, mem_wr}, 16'h0000);
        check_val("rst_addr", mem_addr, 16'h0000);
        check_val("rst_rdy", {15'd0, in_ready}, 16'h0000);
        reset = 1'b0;
        #1;
        check_val("rdy_after_rst", {15'd0, in_ready}, 16'h0001);

        // Immediate load
        issue_imm(15'h1234);
        check_val("imm_a", a_reg, 16'h1234);
        check_val("imm_pc", pc, 16'h0001);
        check_val("imm_wr", {15'd0, mem_wr}, 16'h0000);

        // Write with D update and delayed ack; upstream holds inputs while stalled
        issue_imm(15'h0010);
        issue_c(3'b011, 3'b000, 16'hBEEF, 1'b0, 1'b0);
        check_val("wr_d", d_reg, 16'hBEEF);
        check_val("wr_a", a_reg, 16'h0010);
        check_val("wr_pc", pc, 16'h0003);
        check_val("wr_wr", {15'd0, mem_wr}, 16'h0001);
        check_val("wr_addr", mem_addr, 16'h0010);
        check_val("wr_wdata", mem_wdata, 16'hBEEF);
        check_val("wr_rdy", {15'd0, in_ready}, 16'h0000);
        in_valid = 1'b1;
        dest     = 3'b111;
        alu_out  = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("hold_wr", {15'd0, mem_wr}, 16'h0001);
            check_val("hold_addr", mem_addr, 16'h0010);
            check_val("hold_wdata", mem_wdata, 16'hBEEF);
            check_val("hold_pc", pc, 16'h0003);
            check_val("hold_a", a_reg, 16'h0010);
        end
        idle_inputs();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check_val("ack_wr", {15'd0, mem_wr}, 16'h0000);
        check_val("ack_rdy", {15'd0, in_ready}, 16'h0001);
        check_val("ack_pc", pc, 16'h0003);

        // Stray ack in IDLE has no effect
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check_val("stray_ack_wr", {15'd0, mem_wr}, 16'h0000);
        check_val("stray_ack_rdy", {15'd0, in_ready}, 16'h0001);

        // Taken jump uses old A even when A is rewritten
        issue_imm(15'h0040);
        issue_c(3'b100, 3'b010, 16'h0099, 1'b1, 1'b0);
        check_val("jeq_pc", pc, 16'h0040);
        check_val("jeq_a", a_reg, 16'h0099);

        // Set A=0xFFFF, jump there, then not-taken JGT wraps the PC
        issue_c(3'b100, 3'b000, 16'hFFFF, 1'b0, 1'b0);
        check_val("nojmp_pc", pc, 16'h0041);
        issue_c(3'b000, 3'b001, 16'h0005, 1'b0, 1'b0);
        check_val("jgt_pc", pc, 16'hFFFF);
        issue_c(3'b000, 3'b001, 16'h8000, 1'b0, 1'b1);
        check_val("wrap_pc", pc, 16'h0000);
        issue_c(3'b000, 3'b100, 16'h8000, 1'b0, 1'b1);
        check_val("jlt_pc", pc, 16'hFFFF);

        // Reset during the second MEMWAIT cycle abandons the write
        issue_imm(15'h0055);
        issue_c(3'b011, 3'b000, 16'h1111, 1'b0, 1'b0);
        check_val("mw_wr", {15'd0, mem_wr}, 16'h0001);
        step();
        reset = 1'b1;
        step();
        check_val("mwrst_wr", {15'd0, mem_wr}, 16'h0000);
        check_val("mwrst_a", a_reg, 16'h0000);
        check_val("mwrst_d", d_reg, 16'h0000);
        check_val("mwrst_pc", pc, 16'h0000);
        check_val("mwrst_addr", mem_addr, 16'h0000);
        check_val("mwrst_wdata", mem_wdata, 16'h0000);
        check_val("mwrst_rdy", {15'd0, in_ready}, 16'h0000);
        reset = 1'b0;
        step();
        check_val("mwrst_rdy2", {15'd0, in_ready}, 16'h0001);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check_val("mwrst_ack_wr", {15'd0, mem_wr}, 16'h0000);

`ifdef RETIRE_COUNTER_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("ret_rst", retired, 16'd0);
        issue_imm(15'h0001);
        issue_imm(15'h0002);
        issue_imm(15'h0003);
        check_val("ret_3imm", retired, 16'd3);
        issue_c(3'b001, 3'b000, 16'h00AA, 1'b0, 1'b0);
        check_val("ret_wr_pending", retired, 16'd3);
        step();
        check_val("ret_wr_wait", retired, 16'd3);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check_val("ret_acked", retired, 16'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
